peach_mem_responder: RTL and testbench

Memory-side responder for the Peach RV32I multi-cycle core: it owns a word-organised RAM and answers one fetch/load/store request at a time over a valid/ready request channel and a valid/ready response channel. It applies RV32I byte/half/word semantics from the instruction's funct3 field, including store byte lanes, load sign/zero extension and fault detection. The core's FSM is the initiator, and this block replaces the combinational ROM lookup on the core's memory port.

---
 rtl/peach_mem_responder_if.sv | 25 ++
 rtl/peach_mem_responder.sv | 141 ++++++++++++++
 tb/tb_peach_mem_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/peach_mem_responder_if.sv
// rtl/peach_mem_responder_if.sv - request/response channel bundle between core and memory responder
interface peach_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   // Core side: issues requests, consumes responses.
   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   // Memory side: accepts requests, produces responses.
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/peach_mem_responder.sv
// rtl/peach_mem_responder.sv - RV32I byte/half/word RAM responder; optional boot clear under PEACH_MEM_BOOT_CLEAR_EN
module peach_mem_responder #(
   parameter int DEPTH_WORDS = 4096,
   parameter     INIT_FILE   = "rom.txt"
) (
   input logic                  clk,
   input logic                  reset,
   peach_mem_responder_if.slave bus
);
   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

`ifdef PEACH_MEM_BOOT_CLEAR_EN
   typedef enum logic [1:0] {IDLE, RESP, CLEAR} state_t;
   localparam state_t RESET_STATE = CLEAR;
`else
   typedef enum logic {IDLE, RESP} state_t;
   localparam state_t RESET_STATE = IDLE;
`endif

   state_t      state, state_next;
   logic [31:0] mem [0:DEPTH_WORDS-1];
   logic [31:0] rdata_q;
   logic        err_q;

   logic [AW-1:0] word_idx;
   logic          range_err, align_err, funct3_err, fault, accept;
   logic [31:0]   word, load_val, store_lanes;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [3:0]    byte_en;

   assign word_idx   = bus.req_addr[AW+1:2];
   assign range_err  = {2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS);
   assign align_err  = (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) ||
                       (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'd0);
   assign funct3_err = bus.req_we ? (bus.req_funct3 > 3'd2)
                                  : (bus.req_funct3 == 3'd3 || bus.req_funct3 >= 3'd6);
   assign fault      = range_err || align_err || funct3_err;
   // Reset gating keeps an asserted reset from letting a request slip in.
   assign accept     = bus.req_valid && bus.req_ready && !reset;

   assign word     = mem[word_idx];
   assign byte_sel = word[8*bus.req_addr[1:0] +: 8];
   assign half_sel = bus.req_addr[1] ? word[31:16] : word[15:0];

   // Load extraction and store lane steering, both keyed by funct3 and addr[1:0].
   always_comb begin
      load_val    = word;
      byte_en     = 4'b1111;
      store_lanes = bus.req_wdata;
      case (bus.req_funct3)
         3'd0: load_val = {{24{byte_sel[7]}}, byte_sel};
         3'd1: load_val = {{16{half_sel[15]}}, half_sel};
         3'd4: load_val = {24'd0, byte_sel};
         3'd5: load_val = {16'd0, half_sel};
         default: load_val = word;
      endcase
      case (bus.req_funct3)
         3'd0: begin
            byte_en     = 4'b0001 << bus.req_addr[1:0];
            store_lanes = {4{bus.req_wdata[7:0]}};
         end
         3'd1: begin
            byte_en     = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            store_lanes = {2{bus.req_wdata[15:0]}};
         end
         default: begin
            byte_en     = 4'b1111;
            store_lanes = bus.req_wdata;
         end
      endcase
   end

`ifdef PEACH_MEM_BOOT_CLEAR_EN
   logic [AW-1:0] clr_idx;

   // Boot-clear word pointer; restarts from word 0 on every reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                clr_idx <= '0;
      else if (state == CLEAR)  clr_idx <= clr_idx + 1'b1;
   end
`endif

   // RAM writes: boot clear, or byte-enabled store on a fault-free accept.
   always_ff @(posedge clk) begin
`ifdef PEACH_MEM_BOOT_CLEAR_EN
      if (!reset && state == CLEAR) mem[clr_idx] <= '0;
      else
`endif
      if (accept && bus.req_we && !fault) begin
         for (int b = 0; b < 4; b++)
            if (byte_en[b]) mem[word_idx][8*b +: 8] <= store_lanes[8*b +: 8];
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RESET_STATE;
      else       state <= state_next;
   end

   // Next state and state-decoded handshake outputs.
   always_comb begin
      state_next     = state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_next = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) state_next = IDLE;
         end
`ifdef PEACH_MEM_BOOT_CLEAR_EN
         CLEAR: begin
            if (clr_idx == AW'(DEPTH_WORDS - 1)) state_next = IDLE;
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   // Response payload: captured at accept, zeroed when the response is taken.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         rdata_q <= (fault || bus.req_we) ? 32'd0 : load_val;
         err_q   <= fault;
      end else if (state == RESP && bus.resp_ready) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end
   end

   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_peach_mem_responder.sv
// tb/tb_peach_mem_responder.sv - self-checking bench for peach_mem_responder with byte-array reference model
module tb_peach_mem_responder;
   localparam int DEPTH = 16;
   localparam int BYTES = 4 * DEPTH;
`ifdef PEACH_MEM_BOOT_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [7:0]  mb [BYTES];
   logic [31:0] got_rdata;
   logic        got_err;

   peach_mem_responder_if bus();

   peach_mem_responder #(.DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: byte-addressed little-endian memory, RV32I access rules.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic err);
      int  n;
      bit  legal;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      n     = 1 << f3[1:0];
      err   = !legal || (addr >= 32'(BYTES)) || ((addr % n) != 0);
      rd    = '0;
      if (!err) begin
         if (we) begin
            for (int i = 0; i < n; i++) mb[addr + i] = wdata[8*i +: 8];
         end else begin
            for (int i = 0; i < n; i++) rd[8*i +: 8] = mb[addr + i];
            if (!f3[2] && n < 4 && rd[8*n - 1]) rd = rd | ~((32'd1 << (8*n)) - 1);
         end
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (bus.req_ready !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
   endtask

   // One request: accept, check response one cycle later, optional stall, then handshake.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall);
      logic [31:0] exp_rd;
      logic        exp_err;
      wait_ready();
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
      bus.req_addr = addr; bus.req_wdata = wdata; bus.resp_ready = 1'b0;
      @(posedge clk); #1;
      bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
      model(we, f3, addr, wdata, exp_rd, exp_err);
      chk("resp_valid_latency", {31'd0, bus.resp_valid}, 32'd1);
      chk("req_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
      chk("resp_rdata", bus.resp_rdata, exp_rd);
      chk("resp_err", {31'd0, bus.resp_err}, {31'd0, exp_err});
      got_rdata = bus.resp_rdata;
      got_err   = bus.resp_err;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
      end
      if (stall > 0) chk("resp_rdata_stall", bus.resp_rdata, exp_rd);
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      chk("resp_valid_clear", {31'd0, bus.resp_valid}, 32'd0);
      chk("rdata_err_clear", {bus.resp_rdata[30:0], bus.resp_err}, 32'd0);
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd2;
      bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
      for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;

      // Reset state
      #12;
      chk("reset_req_ready", {31'd0, bus.req_ready}, {31'd0, !CLR});
      chk("reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("reset_rdata", bus.resp_rdata, 32'd0);
      chk("reset_err", {31'd0, bus.resp_err}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      if (CLR) begin
         // Boot clear: ready held low for DEPTH cycles, then every word reads 0.
         for (int i = 0; i < DEPTH; i++) begin
            chk("clear_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
            @(posedge clk); #1;
         end
         chk("clear_done_ready", {31'd0, bus.req_ready}, 32'd1);
         for (int w = 0; w < DEPTH; w++) begin
            do_req(1'b0, 3'd2, 32'(4*w), 32'd0, 0);
            chk("clear_word_zero", got_rdata, 32'd0);
         end
      end else begin
         // Give the model a known image by writing every word.
         for (int w = 0; w < DEPTH; w++) do_req(1'b1, 3'd2, 32'(4*w), 32'd0, 0);
      end

      // SW then LW
      do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
      do_req(1'b0, 3'd2, 32'h10, 32'd0, 0);
      chk("sw_lw", got_rdata, 32'hDEADBEEF);

      // SB then byte loads
      do_req(1'b1, 3'd2, 32'h10, 32'h0, 0);
      do_req(1'b1, 3'd0, 32'h11, 32'h80, 0);
      do_req(1'b0, 3'd0, 32'h11, 32'd0, 0);
      chk("lb_sign", got_rdata, 32'hFFFFFF80);
      do_req(1'b0, 3'd4, 32'h11, 32'd0, 0);
      chk("lbu_zero", got_rdata, 32'h00000080);
      do_req(1'b0, 3'd2, 32'h10, 32'd0, 0);
      chk("sb_lane", got_rdata, 32'h00008000);

      // Halfword and misalignment
      do_req(1'b1, 3'd1, 32'h22, 32'h1234ABCD, 0);
      do_req(1'b0, 3'd5, 32'h22, 32'd0, 0);
      chk("lhu", got_rdata, 32'h0000ABCD);
      do_req(1'b0, 3'd1, 32'h22, 32'd0, 0);
      chk("lh", got_rdata, 32'hFFFFABCD);
      do_req(1'b0, 3'd2, 32'h22, 32'd0, 0);
      chk("lw_misaligned_err", {31'd0, got_err}, 32'd1);
      do_req(1'b1, 3'd2, 32'h21, 32'hFFFFFFFF, 0);
      chk("sw_misaligned_err", {31'd0, got_err}, 32'd1);
      do_req(1'b0, 3'd2, 32'h20, 32'd0, 0);
      chk("sw_misaligned_nowrite", got_rdata, 32'hABCD0000);

      // Out-of-range and illegal funct3
      do_req(1'b0, 3'd2, 32'(BYTES), 32'd0, 0);
      chk("lw_range_err", {31'd0, got_err}, 32'd1);
      do_req(1'b0, 3'd3, 32'h0, 32'd0, 0);
      chk("ld_f3_err", {31'd0, got_err}, 32'd1);
      do_req(1'b1, 3'd4, 32'h20, 32'h55555555, 0);
      chk("st_f3_err", {31'd0, got_err}, 32'd1);
      do_req(1'b0, 3'd2, 32'h20, 32'd0, 0);
      chk("st_f3_nowrite", got_rdata, 32'hABCD0000);

      // Backpressure: response held, ready low, stray requests ignored.
      wait_ready();
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h10;
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
      bus.req_addr = 32'h10; bus.req_wdata = 32'h5A5A5A5A;
      for (int i = 0; i < 5; i++) begin
         chk("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
         chk("bp_rdata", bus.resp_rdata, 32'h00008000);
         chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
         @(posedge clk); #1;
      end
      bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      do_req(1'b0, 3'd2, 32'h10, 32'd0, 0);
      chk("bp_ignored_store", got_rdata, 32'h00008000);

      // Reset while a store response is pending.
      begin
         logic [31:0] rd_d;
         logic        err_d;
         wait_ready();
         bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
         bus.req_addr = 32'h30; bus.req_wdata = 32'hCAFEF00D;
         @(posedge clk); #1;
         bus.req_valid = 1'b0;
         model(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, rd_d, err_d);
         chk("pre_reset_valid", {31'd0, bus.resp_valid}, 32'd1);
         #2 reset = 1'b1;
         #1;
         chk("async_reset_valid", {31'd0, bus.resp_valid}, 32'd0);
         chk("async_reset_ready", {31'd0, bus.req_ready}, {31'd0, !CLR});
         @(posedge clk); #1;
         reset = 1'b0;
         if (CLR) for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;
         do_req(1'b0, 3'd2, 32'h30, 32'd0, 0);
         chk("store_survives_reset", got_rdata, CLR ? 32'd0 : 32'hCAFEF00D);
      end

      // Randomized traffic against the reference model.
      for (int t = 0; t < 200; t++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, BYTES + 7));
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
